label_overlay: RTL
==================

// Module: label_overlay
// PURPOSE
//  Composites the 12-row x 4-column frequency-axis text onto the spectrogram RGB pixel stream.
//  Sits between the video timing/spectrogram pixel source and the LCD output pins.
//  Tracks pixel and line position with counters and drives cell addresses to char_map.
//  Feeds the returned code and glyph row index to char_rom, then overlays the glyph bit.
//  All in_* signals reach out_* with a fixed 3-cycle latency.
// PARAMETERS
//  LBL_X0     8        first pixel column of the label area
//  LBL_Y0     4        first line of label row 0
//  ROW_PITCH  40       lines between label rows (>= GLYPH_H)
//  LABEL_RGB  16'hFFFF RGB565 colour for set glyph bits
//  BG_RGB     16'h0000 box colour (LABEL_BG_EN only)
// PORTS
//  ck         in   1   pixel clock
//  rst_n      in   1   async active-low reset
//  in_de      in   1   data enable, active high
//  in_hs      in   1   hsync, passed through delayed
//  in_vs      in   1   vsync, active high; rising edge = frame start
//  in_rgb     in   16  spectrogram pixel, RGB565
//  map_ychr   out  4   char_map row address (registered)
//  map_xchr   out  3   char_map column address (registered)
//  map_chr    in   4   char_map code, valid 1 cycle after address
//  rom_chr    out  4   char_rom code (= map_chr, wired through)
//  rom_scany  out  3   char_rom glyph line (registered, aligned with map_chr)
//  rom_row    in   6   char_rom glyph row, valid 1 cycle after rom_chr; bit5 = leftmost pixel
//  out_de/out_hs/out_vs out 1  in_* delayed 3 cycles
//  out_rgb    out  16  composited pixel
// BEHAVIOUR
//  Reset: all out_*, map_*, rom_scany, counters = 0; frame_ok = 0.
//  Line counter:
//   - cleared on in_vs rising edge, which also sets frame_ok
//   - +1 on each in_de falling edge
//   - split into row index ry (saturates at NROWS) and line-in-row ly (0..ROW_PITCH-1, wraps)
//   - both ry and ly begin counting at line LBL_Y0
//  Pixel counter:
//   - cleared on in_de rising edge
//   - from LBL_X0, split into cell cx (saturates at NCOLS) and bit bx (0..5, wraps)
//  Hit (S0): frame_ok & in_de & line>=LBL_Y0 & ry<NROWS & ly<GLYPH_H & px>=LBL_X0 & cx<NCOLS.
//   - register map_ychr=ry, map_xchr=cx, scany=ly
//  Pipeline:
//   - S1: map_chr valid; rom_scany presented
//   - S2: rom_row valid
//   - S3: out_rgb = (hit & rom_row[5-bx]) ? LABEL_RGB : in_rgb
//   - hit, bx, de, hs, vs, rgb delayed to stay aligned
//  Outside hit: out_rgb = in_rgb, delayed only. Address ports hold their last value.
//  Simultaneous vs rise and de edge: vs clear wins.
//  in_de low mid-cell: pixel counter stops; next line restarts at 0.
//  Reset mid-frame: overlay suppressed (pure passthrough) until next in_vs rise.
//  in_vs rise during de-active: counters clear; the current line is passthrough.
// CONFIGURATION
//  LABEL_BG_EN defined:
//   - hit pixels with glyph bit 0 output BG_RGB (opaque box behind text)
//  LABEL_BG_EN undefined:
//   - hit pixels with glyph bit 0 output in_rgb (transparent)
// STRUCTURE
//  label_pkg holds:
//   - GLYPH_W=6, GLYPH_H=8, NCOLS=4, NROWS=12, PIPE_LAT=3
//   - RGB565 width constant
//  Sub-module label_pos_counter:
//   - edge detect plus line/pixel counters, producing ry, ly, cx, bx, hit
//  Top module: S1..S3 delay pipeline and output mux.
// TESTING
//  1. rst_n=0 with live stimulus:
//     - all outputs 0
//     - after release, before vs: out_rgb == in_rgb delayed 3
//  2. vs pulse, then line 4, px 8..13, map_chr=2, rom_row=6'b001110:
//     - map_ychr=0, map_xchr=0, rom_scany=0
//     - out_rgb at px 10,11,12 = 16'hFFFF, others = in_rgb, 3-cycle lag
//  3. Line 4+40*11+3 (ry=11, ly=3), px 8+3*6 => map_ychr=11, map_xchr=3, rom_scany=3.
//     Line 4+40*12 => passthrough.
//  4. Line 4+8 (ly=8) and px 8+24 (cx=4) => passthrough, out_rgb == in_rgb.
//  5. rst_n pulsed mid-label => passthrough rest of frame; overlay resumes after next vs.
//  6. LABEL_BG_EN, rom_row=0 inside hit => 16'h0000; undefined => in_rgb.

Source files
------------

// File: rtl/label_pkg.sv
// Shared constants and pixel-pipeline types for the frequency-axis label overlay.
// Latency: n/a (definitions only).
// Backpressure: n/a; the video stream cannot stall.
package label_pkg;

    localparam int GLYPH_W  = 6;
    localparam int GLYPH_H  = 8;
    localparam int NCOLS    = 4;
    localparam int NROWS    = 12;
    localparam int PIPE_LAT = 3;
    localparam int RGB_W    = 16;

    typedef logic [RGB_W-1:0] rgb_t;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        rgb_t rgb;
    } vid_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] bx;
    } ovl_t;

endpackage

// File: rtl/label_pos_counter.sv
// Tracks line and pixel position within the frame and flags pixels that fall inside a glyph cell.
// Latency: combinational outputs for the current (S0) pixel; edge state is registered.
// Backpressure: none; follows the free-running video timing.
module label_pos_counter
    import label_pkg::*;
#(
    parameter int LBL_X0    = 8,
    parameter int LBL_Y0    = 4,
    parameter int ROW_PITCH = 40
) (
    input  logic       ck,
    input  logic       rst_n,
    input  logic       in_de,
    input  logic       in_vs,
    output logic [3:0] ry,
    output logic [2:0] scany,
    output logic [2:0] cx,
    output logic [2:0] bx,
    output logic       hit
);

    localparam logic [15:0] X0       = 16'(LBL_X0);
    localparam logic [15:0] Y0       = 16'(LBL_Y0);
    localparam logic [7:0]  PITCH_M1 = 8'(ROW_PITCH - 1);
    localparam logic [7:0]  GH       = 8'(GLYPH_H);
    localparam logic [3:0]  NR       = 4'(NROWS);
    localparam logic [2:0]  NC       = 3'(NCOLS);
    localparam logic [2:0]  BW_M1    = 3'(GLYPH_W - 1);

    logic        vs_d, de_d, frame_ok;
    logic [15:0] lcnt, pcnt;
    logic [3:0]  ry_q;
    logic [7:0]  ly_q;
    logic [2:0]  cx_q, bx_q;
    logic        vs_rise, de_rise, de_fall;
    logic [15:0] pcur, p_n;
    logic [2:0]  cxcur, bxcur, cx_n, bx_n;

    assign vs_rise = in_vs & ~vs_d;
    assign de_rise = in_de & ~de_d;
    assign de_fall = ~in_de & de_d;

    // The first pixel of a line must see a cleared counter in the same cycle.
    assign pcur  = de_rise ? 16'd0 : pcnt;
    assign cxcur = de_rise ? 3'd0  : cx_q;
    assign bxcur = de_rise ? 3'd0  : bx_q;

    assign hit = frame_ok & ~vs_rise & in_de & (lcnt >= Y0) & (ry_q < NR) & (ly_q < GH)
               & (pcur >= X0) & (cxcur < NC);

    assign ry    = ry_q;
    assign scany = ly_q[2:0];
    assign cx    = cxcur;
    assign bx    = bxcur;

    always_comb begin
        p_n  = pcur;
        cx_n = cxcur;
        bx_n = bxcur;
        if (pcur < X0) begin
            p_n = pcur + 16'd1;
        end else if (cxcur < NC) begin
            if (bxcur == BW_M1) begin
                bx_n = 3'd0;
                cx_n = cxcur + 3'd1;
            end else begin
                bx_n = bxcur + 3'd1;
            end
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            vs_d     <= 1'b0;
            de_d     <= 1'b0;
            frame_ok <= 1'b0;
            lcnt     <= '0;
            ry_q     <= '0;
            ly_q     <= '0;
            pcnt     <= '0;
            cx_q     <= '0;
            bx_q     <= '0;
        end else begin
            vs_d <= in_vs;
            de_d <= in_de;
            if (in_de) begin
                pcnt <= p_n;
                cx_q <= cx_n;
                bx_q <= bx_n;
            end
            // Frame start takes priority over any coincident line edge.
            if (vs_rise) begin
                frame_ok <= 1'b1;
                lcnt     <= '0;
                ry_q     <= '0;
                ly_q     <= '0;
            end else if (de_fall) begin
                if (lcnt < Y0) begin
                    lcnt <= lcnt + 16'd1;
                end else if (ly_q == PITCH_M1) begin
                    ly_q <= '0;
                    if (ry_q < NR) ry_q <= ry_q + 4'd1;
                end else begin
                    ly_q <= ly_q + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/label_overlay.sv
// Overlays 12x4 frequency-axis glyphs on the RGB565 stream; LABEL_BG_EN selects an opaque box.
// Latency: fixed 3 cycles from in_* to out_*; char_map/char_rom lookups overlap S1/S2.
// Backpressure: none; pixels advance every clock, address ports hold outside the label area.
module label_overlay
    import label_pkg::*;
#(
    parameter int          LBL_X0    = 8,
    parameter int          LBL_Y0    = 4,
    parameter int          ROW_PITCH = 40,
    parameter logic [15:0] LABEL_RGB = 16'hFFFF,
    parameter logic [15:0] BG_RGB    = 16'h0000
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        in_de,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [15:0] in_rgb,
    output logic [3:0]  map_ychr,
    output logic [2:0]  map_xchr,
    input  logic [3:0]  map_chr,
    output logic [3:0]  rom_chr,
    output logic [2:0]  rom_scany,
    input  logic [5:0]  rom_row,
    output logic        out_de,
    output logic        out_hs,
    output logic        out_vs,
    output logic [15:0] out_rgb
);

`ifdef LABEL_BG_EN
    localparam logic BG_EN = 1'b1;
`else
    localparam logic BG_EN = 1'b0;
`endif

    localparam int          ND    = PIPE_LAT - 1;
    localparam logic [2:0]  BW_M1 = 3'(GLYPH_W - 1);

    logic [3:0] ry;
    logic [2:0] scany, cx, bx;
    logic       hit;
    vid_t       vpipe [ND];
    ovl_t       opipe [ND];
    logic [2:0] bit_idx;
    logic       glyph_bit;
    rgb_t       pix;

    label_pos_counter #(
        .LBL_X0    (LBL_X0),
        .LBL_Y0    (LBL_Y0),
        .ROW_PITCH (ROW_PITCH)
    ) u_pos (
        .ck    (ck),
        .rst_n (rst_n),
        .in_de (in_de),
        .in_vs (in_vs),
        .ry    (ry),
        .scany (scany),
        .cx    (cx),
        .bx    (bx),
        .hit   (hit)
    );

    assign rom_chr = map_chr;

    // rom_row bit 5 is the leftmost pixel of the glyph line.
    assign bit_idx   = BW_M1 - opipe[ND-1].bx;
    assign glyph_bit = rom_row[bit_idx];

    always_comb begin
        pix = vpipe[ND-1].rgb;
        if (opipe[ND-1].hit && glyph_bit) pix = LABEL_RGB;
        else if (opipe[ND-1].hit && BG_EN) pix = BG_RGB;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            map_ychr  <= '0;
            map_xchr  <= '0;
            rom_scany <= '0;
            for (int i = 0; i < ND; i++) begin
                vpipe[i] <= '0;
                opipe[i] <= '0;
            end
            out_de  <= 1'b0;
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_rgb <= '0;
        end else begin
            if (hit) begin
                map_ychr  <= ry;
                map_xchr  <= cx;
                rom_scany <= scany;
            end
            vpipe[0] <= '{de: in_de, hs: in_hs, vs: in_vs, rgb: in_rgb};
            opipe[0] <= '{hit: hit, bx: bx};
            for (int i = 1; i < ND; i++) begin
                vpipe[i] <= vpipe[i-1];
                opipe[i] <= opipe[i-1];
            end
            out_de  <= vpipe[ND-1].de;
            out_hs  <= vpipe[ND-1].hs;
            out_vs  <= vpipe[ND-1].vs;
            out_rgb <= pix;
        end
    end

endmodule
